// File: rtl/imm_seq_ext_shifter.sv
// -----------------------------------------------------------------------------
// imm_seq_ext_shifter
//
// Purpose:
//   Takes a raw immediate field and sign- or zero-extends it from a run-time
//   selectable source width. It then shifts the result left, right-logical or
//   right-arithmetic by up to 2^SHAMT_WIDTH-1 positions. The shift is
//   sequential: one bit position is shifted per clock.
//   The cycle that accepts an operation also performs its first shift step, so
//   a result is presented max(shift_amt,1) cycles after acceptance.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - asynchronous active-low reset
//   in_valid   - operation request
//   in_ready   - request accepted when in_valid && in_ready
//   data_in    - raw immediate (DATA_IN_WIDTH bits)
//   src_width  - number of valid LSBs in data_in (clamped to DATA_IN_WIDTH)
//   sign_ext   - 1: sign-extend from bit src_width-1, 0: zero-extend
//   shift_amt  - number of bit positions to shift
//   shift_dir  - 0: left, 1: right
//   arith      - right shifts fill with the current MSB when 1
//   out_valid  - data_out holds a finished result
//   out_ready  - result consumed when out_valid && out_ready
//   data_out   - extended and shifted result (DATA_OUT_WIDTH bits)
//   busy       - high while shift steps remain after the accept cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module imm_seq_ext_shifter #(
    parameter int DATA_IN_WIDTH  = 12,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int SHAMT_WIDTH    = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_IN_WIDTH-1:0]           data_in,
    input  logic [$clog2(DATA_IN_WIDTH+1)-1:0] src_width,
    input  logic                               sign_ext,
    input  logic [SHAMT_WIDTH-1:0]             shift_amt,
    input  logic                               shift_dir,
    input  logic                               arith,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_OUT_WIDTH-1:0]          data_out,
    output logic                               busy
);

    localparam int SRC_W = $clog2(DATA_IN_WIDTH + 1);

    localparam logic [SHAMT_WIDTH-1:0] CNT_ZERO = {SHAMT_WIDTH{1'b0}};
    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    state_t                    launch_state_s;
    logic [DATA_OUT_WIDTH-1:0] work_q, work_d;
    logic [DATA_OUT_WIDTH-1:0] ext_s;
    logic [SHAMT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                      dir_q, dir_d;
    logic                      arith_q, arith_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;
    logic                      ready_en_q, ready_en_d;
    logic                      in_ready_s;
    logic                      accept_s;

    // Extend raw[width-1:0] to the datapath width; widths above DATA_IN_WIDTH
    // are clamped and a width of zero yields zero regardless of sext.
    function automatic logic [DATA_OUT_WIDTH-1:0] extend_imm(
        input logic [DATA_IN_WIDTH-1:0] raw,
        input logic [SRC_W-1:0]         width,
        input logic                     sext
    );
        int                        eff;
        logic                      fill;
        logic [DATA_OUT_WIDTH-1:0] res;
        eff  = (int'(width) > DATA_IN_WIDTH) ? DATA_IN_WIDTH : int'(width);
        fill = 1'b0;
        res  = {DATA_OUT_WIDTH{1'b0}};
        for (int i = 0; i < DATA_IN_WIDTH; i++) begin
            if (i < eff) begin
                res[i] = raw[i];
            end else begin
                res[i] = 1'b0;
            end
            // Scan for the top kept bit instead of indexing with eff-1 so the
            // select always stays inside raw.
            if (sext && (i == eff - 1)) begin
                fill = raw[i];
            end else begin
                fill = fill;
            end
        end
        for (int i = 0; i < DATA_OUT_WIDTH; i++) begin
            if (i >= eff) begin
                res[i] = fill;
            end else begin
                res[i] = res[i];
            end
        end
        return res;
    endfunction

    // One shift step. Repeating it saturates naturally for long shifts:
    // zeros for left/logical right, sign copies for arithmetic right.
    function automatic logic [DATA_OUT_WIDTH-1:0] shift_one(
        input logic [DATA_OUT_WIDTH-1:0] v,
        input logic                      right,
        input logic                      arith_fill
    );
        logic [DATA_OUT_WIDTH-1:0] res;
        if (right) begin
            res = {arith_fill & v[DATA_OUT_WIDTH-1], v[DATA_OUT_WIDTH-1:1]};
        end else begin
            res = {v[DATA_OUT_WIDTH-2:0], 1'b0};
        end
        return res;
    endfunction

    // Handshake: ready in IDLE, or in DONE when the current result is being
    // consumed. The ready_en gate holds ready low until the first edge after reset.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_s = ready_en_q;
            ST_DONE: in_ready_s = ready_en_q & out_ready;
            default: in_ready_s = 1'b0;
        endcase
        accept_s = in_valid & in_ready_s;
    end

    // Next state. The accept cycle does the first shift step, so only
    // shift_amt > 1 needs SHIFT cycles.
    always_comb begin
        state_d = state_q;
        if (shift_amt > CNT_ONE) begin
            launch_state_s = ST_SHIFT;
        end else begin
            launch_state_s = ST_DONE;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = launch_state_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // cnt_q counts remaining steps including this one; "<=" also
                // exits cleanly if the counter were ever corrupted to zero.
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_d = launch_state_s;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered status outputs follow the state being entered.
    always_comb begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            ST_DONE:  out_valid_d = 1'b1;
            ST_SHIFT: busy_d      = 1'b1;
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Datapath: capture and first step on accept, one step per SHIFT cycle.
    // Otherwise hold, so data_out keeps its last value after consumption.
    always_comb begin
        work_d     = work_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        arith_d    = arith_q;
        ready_en_d = 1'b1;
        ext_s      = extend_imm(data_in, src_width, sign_ext);
        if (accept_s) begin
            dir_d   = shift_dir;
            arith_d = arith;
            if (shift_amt == CNT_ZERO) begin
                work_d = ext_s;
                cnt_d  = CNT_ZERO;
            end else begin
                work_d = shift_one(ext_s, shift_dir, arith);
                cnt_d  = shift_amt - CNT_ONE;
            end
        end else if (state_q == ST_SHIFT) begin
            work_d = shift_one(work_q, dir_q, arith_q);
            cnt_d  = cnt_q - CNT_ONE;
        end else begin
            work_d = work_q;
            cnt_d  = cnt_q;
        end
    end

    // State and datapath registers. Reset clears everything immediately,
    // including an operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            work_q      <= {DATA_OUT_WIDTH{1'b0}};
            cnt_q       <= CNT_ZERO;
            dir_q       <= 1'b0;
            arith_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            arith_q     <= arith_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ready_en_q  <= ready_en_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign data_out  = work_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_imm_seq_ext_shifter.sv
// -----------------------------------------------------------------------------
// Testbench for imm_seq_ext_shifter (DATA_IN_WIDTH=12, DATA_OUT_WIDTH=16,
// SHAMT_WIDTH=4). Stimulus pushes expected results into a queue when an
// operation is issued. A monitor on the falling edge tracks handshakes, then
// checks latency, busy duration, hold stability and the consumed data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_imm_seq_ext_shifter;

    localparam int DIW = 12;
    localparam int DOW = 16;
    localparam int SHW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [DIW-1:0]  data_in;
    logic [3:0]      src_width;
    logic            sign_ext;
    logic [SHW-1:0]  shift_amt;
    logic            shift_dir;
    logic            arith;
    logic            out_valid;
    logic            out_ready;
    logic [DOW-1:0]  data_out;
    logic            busy;

    imm_seq_ext_shifter #(
        .DATA_IN_WIDTH (DIW),
        .DATA_OUT_WIDTH(DOW),
        .SHAMT_WIDTH   (SHW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .src_width(src_width),
        .sign_ext (sign_ext),
        .shift_amt(shift_amt),
        .shift_dir(shift_dir),
        .arith    (arith),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } exp_t;

    typedef struct {
        logic [11:0] d;
        logic [3:0]  sw;
        logic        se;
        logic [3:0]  n;
        logic        r;
        logic        ar;
        logic [15:0] e;
    } dir_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   n_total  = 0;
    int   n_pass   = 0;
    int   rdy_mode = 2;   // 0: random, 1: held low, 2: held high

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference: mask/extend with integer arithmetic, then one whole shift.
    function automatic logic [15:0] ref_model(input logic [11:0] d, input int sw, input logic se,
                                              input int n, input logic right, input logic ar);
        int                 eff;
        longint             mask;
        longint             v;
        logic signed [15:0] s;
        eff  = (sw > DIW) ? DIW : sw;
        mask = (64'd1 << eff) - 64'd1;
        v    = longint'(d) & mask;
        if (se && eff > 0 && (((longint'(d) >> (eff - 1)) & 64'd1) == 64'd1)) begin
            v = v | ((~mask) & 64'hFFFF);
        end
        if (!right) begin
            v = (v << n) & 64'hFFFF;
        end else if (ar) begin
            s = v[15:0];
            s = s >>> n;
            v = longint'(s) & 64'hFFFF;
        end else begin
            v = v >> n;
        end
        return v[15:0];
    endfunction

    task automatic drive_op(input logic [11:0] d, input logic [3:0] sw, input logic se,
                            input logic [3:0] n, input logic r, input logic ar,
                            input logic [15:0] expv);
        exp_t item;
        data_in   = d;
        src_width = sw;
        sign_ext  = se;
        shift_amt = n;
        shift_dir = r;
        arith     = ar;
        in_valid  = 1'b1;
        item.data = expv;
        item.lat  = (n == 4'd0) ? 1 : int'(n);
        exp_q.push_back(item);
    endtask

    // Waits (bounded) for the handshake, then drops in_valid and scrambles
    // the operand inputs one edge later.
    task automatic wait_accept();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_wait", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        data_in   = 12'($urandom);
        src_width = 4'($urandom_range(0, 15));
        sign_ext  = 1'($urandom_range(0, 1));
        shift_amt = 4'($urandom_range(0, 15));
        shift_dir = 1'($urandom_range(0, 1));
        arith     = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [11:0] d, input logic [3:0] sw, input logic se,
                         input logic [3:0] n, input logic r, input logic ar,
                         input logic [15:0] expv);
        drive_op(d, sw, se, n, r, ar, expv);
        wait_accept();
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    // out_ready driver; acts 2 time units after the edge so that mode changes
    // made by stimulus at +1 apply within the same cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard
    int          mon_idx  = 0;
    int          busy_cnt = 0;
    logic        lat_done = 1'b0;
    logic [15:0] held     = 16'h0000;

    initial begin
        forever begin
            @(negedge clk);
            mon_idx++;
            if (!reset_n) begin
                exp_q.delete();
                acc_q.delete();
                lat_done = 1'b0;
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (out_valid && !lat_done) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        chk("spurious_valid", {31'd0, out_valid}, 32'd0);
                    end else begin
                        chk("latency", mon_idx - acc_q[0], exp_q[0].lat);
                        chk("busy_cycles", busy_cnt, exp_q[0].lat - 1);
                    end
                    lat_done = 1'b1;
                    held     = data_out;
                end else if (out_valid) begin
                    chk("hold_stable", {16'd0, data_out}, {16'd0, held});
                end
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    chk("data_out", {16'd0, data_out}, {16'd0, exp_q[0].data});
                    void'(exp_q.pop_front());
                    if (acc_q.size() > 0) void'(acc_q.pop_front());
                    lat_done = 1'b0;
                end
                if (in_valid && in_ready) begin
                    acc_q.push_back(mon_idx);
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    dir_t dirs[7] = '{
        '{12'h0F0, 4'd8,  1'b1, 4'd1,  1'b0, 1'b0, 16'hFFE0},
        '{12'h800, 4'd12, 1'b1, 4'd3,  1'b1, 1'b1, 16'hFF00},
        '{12'hABC, 4'd12, 1'b0, 4'd4,  1'b1, 1'b0, 16'h00AB},
        '{12'hFFF, 4'd0,  1'b1, 4'd0,  1'b0, 1'b0, 16'h0000},
        '{12'hFFF, 4'd15, 1'b1, 4'd0,  1'b0, 1'b0, 16'hFFFF},
        '{12'h001, 4'd12, 1'b0, 4'd15, 1'b0, 1'b0, 16'h8000},
        '{12'h800, 4'd12, 1'b1, 4'd15, 1'b1, 1'b1, 16'hFFFF}
    };

    initial begin
        logic [11:0] rd;
        logic [3:0]  rsw;
        logic        rse;
        logic [3:0]  rn;
        logic        rr;
        logic        rar;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        data_in   = 12'h000;
        src_width = 4'd0;
        sign_ext  = 1'b0;
        shift_amt = 4'd0;
        shift_dir = 1'b0;
        arith     = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data_out", {16'd0, data_out}, 32'd0);
        #9;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Directed cases with fixed expected values
        rdy_mode = 2;
        for (int i = 0; i < 7; i++) begin
            issue(dirs[i].d, dirs[i].sw, dirs[i].se, dirs[i].n, dirs[i].r, dirs[i].ar, dirs[i].e);
        end
        drain();

        // Backpressure in DONE with a pending request, then simultaneous
        // consume and accept.
        rdy_mode = 1;
        issue(12'h0F0, 4'd12, 1'b0, 4'd2, 1'b0, 1'b0, 16'h03C0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk);
        #1;
        drive_op(12'h7FF, 4'd11, 1'b1, 4'd2, 1'b1, 1'b1, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        rdy_mode = 2;
        wait_accept();
        drain();

        // Reset in the middle of a long shift
        issue(12'h0F0, 4'd12, 1'b0, 4'd15, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_data_out", {16'd0, data_out}, 32'd0);
        #5;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_abort", {31'd0, in_ready}, 32'd1);
        chk("no_partial_valid", {31'd0, out_valid}, 32'd0);
        issue(12'hABC, 4'd12, 1'b1, 4'd5, 1'b1, 1'b1,
              ref_model(12'hABC, 12, 1'b1, 5, 1'b1, 1'b1));
        drain();

        // Randomized operations with random output backpressure
        rdy_mode = 0;
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            rd  = 12'($urandom);
            rsw = 4'($urandom_range(0, 15));
            rse = 1'($urandom_range(0, 1));
            rn  = 4'($urandom_range(0, 15));
            rr  = 1'($urandom_range(0, 1));
            rar = 1'($urandom_range(0, 1));
            issue(rd, rsw, rse, rn, rr, rar,
                  ref_model(rd, int'(rsw), rse, int'(rn), rr, rar));
        end
        rdy_mode = 2;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
